// File: rtl/bidir_bus_ctrl.sv
// bidir_bus_ctrl
//   Sequencer in front of bidir_buf. Turns single-beat read/write commands
//   into timed bus phases (drive -> turnaround for writes, sample for reads)
//   and returns read data on a valid/ready response channel. oe only rises
//   from IDLE, and IDLE after a write is only reachable through TURN, so the
//   bus is always released for TURN_CYCLES before it can be driven again.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_wr selects write(1)/read(0),
//   cmd_wr, cmd_wdata   both sampled only at acceptance
//   rsp_valid/ready     read response handshake, rsp_rdata = captured bus
//   buf_oe, buf_in      to bidir_buf (registered)
//   buf_out             bus value from bidir_buf
//   busy                high whenever not IDLE
//   wr_count, rd_count  completed write/read counters, saturating
//                       (present only with BIDIR_BUS_CTRL_TXN_CNT_EN)
module bidir_bus_ctrl #(
  parameter int WIDTH         = 8,
  parameter int DRIVE_CYCLES  = 2,
  parameter int TURN_CYCLES   = 1,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_wr,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             buf_oe,
  output logic [WIDTH-1:0] buf_in,
  input  logic [WIDTH-1:0] buf_out,
  output logic             busy
`ifdef BIDIR_BUS_CTRL_TXN_CNT_EN
  ,
  output logic [15:0]      wr_count,
  output logic [15:0]      rd_count
`endif
);

  localparam int MAX_DT = (DRIVE_CYCLES > TURN_CYCLES) ? DRIVE_CYCLES : TURN_CYCLES;
  localparam int MAXC   = (MAX_DT > SAMPLE_CYCLES) ? MAX_DT : SAMPLE_CYCLES;
  localparam int CW     = $clog2(MAXC) + 1;

  // Counter holds "cycles left after this one" in the current phase.
  localparam logic [CW-1:0] DRV_LD = CW'(DRIVE_CYCLES - 1);
  localparam logic [CW-1:0] TRN_LD = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] SMP_LD = CW'(SAMPLE_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_TURN, S_SAMPLE, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             buf_oe_q, buf_oe_d;
  logic [WIDTH-1:0] buf_in_q, buf_in_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_oe_d    = buf_oe_q;
    buf_in_d    = buf_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        buf_oe_d = 1'b0;
        if (cmd_valid) begin
          if (cmd_wr) begin
            buf_in_d = cmd_wdata;
            buf_oe_d = 1'b1;
            state_d  = S_DRIVE;
            cnt_d    = DRV_LD;
          end else begin
            state_d = S_SAMPLE;
            cnt_d   = SMP_LD;
          end
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) begin
          buf_oe_d = 1'b0;
          state_d  = S_TURN;
          cnt_d    = TRN_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_TURN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SAMPLE: begin
        // buf_out is only looked at on the final sample cycle
        if (cnt_q == '0) begin
          rsp_rdata_d = buf_out;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        buf_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      buf_oe_q    <= 1'b0;
      buf_in_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_oe_q    <= buf_oe_d;
      buf_in_q    <= buf_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign buf_oe    = buf_oe_q;
  assign buf_in    = buf_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef BIDIR_BUS_CTRL_TXN_CNT_EN
  logic [15:0] wr_count_q, wr_count_d;
  logic [15:0] rd_count_q, rd_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    if (state_q == S_TURN && cnt_q == '0 && wr_count_q != 16'hFFFF)
      wr_count_d = wr_count_q + 16'd1;
    if (state_q == S_RESP && rsp_ready && rd_count_q != 16'hFFFF)
      rd_count_d = rd_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Bench for bidir_bus_ctrl (default parameters). A timeline model predicts
// every output from acceptance times: a write accepted in cycle c drives oe
// in cycles c+1..c+D and frees the controller at c+D+T+1; a read accepted in
// cycle c captures the bus of cycle c+S and presents it from c+S+1 until the
// handshake. The bench plays the far-end driver whenever oe is expected low.
module tb_bidir_bus_ctrl;
  localparam int D = 2, T = 1, S = 2;

  logic       clk, rst;
  logic       cmd_valid, cmd_wr, rsp_ready;
  logic [7:0] cmd_wdata;
  logic       cmd_ready, rsp_valid, buf_oe, busy;
  logic [7:0] rsp_rdata, buf_in, buf_out;
  logic       drv_en;
  logic [7:0] drv_val;
`ifdef BIDIR_BUS_CTRL_TXN_CNT_EN
  logic [15:0] wr_count, rd_count;
`endif

  bidir_bus_ctrl #(.WIDTH(8), .DRIVE_CYCLES(D), .TURN_CYCLES(T), .SAMPLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .buf_oe(buf_oe), .buf_in(buf_in), .buf_out(buf_out), .busy(busy)
`ifdef BIDIR_BUS_CTRL_TXN_CNT_EN
    , .wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  // Behaviour of bidir_buf plus the far-end driver.
  assign buf_out = buf_oe ? buf_in : (drv_en ? drv_val : 8'hxx);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int k = 0;
  // timeline model
  int ready_at = 0, oe_lo = 0, oe_hi = -1;
  int cap_cyc = -1, rsp_from = 0, wr_done = -1;
  bit rd_pend = 0;
  logic [7:0] m_buf_in = 0, m_rdata = 0;
  int m_wr_cnt = 0, m_rd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    ready_at = k + 1; oe_lo = 0; oe_hi = -1;
    cap_cyc = -1; wr_done = -1; rd_pend = 0;
    m_buf_in = 0; m_rdata = 0; m_wr_cnt = 0; m_rd_cnt = 0;
  endtask

  // One clock cycle: drive inputs, check outputs, advance model, clock edge.
  task automatic tick(input bit v, input bit wr, input logic [7:0] wd, input bit rr,
                      input bit r, input logic [7:0] bus, input bit chk_en);
    bit exp_oe, exp_rdy, exp_rv;
    exp_oe  = (k >= oe_lo) && (k <= oe_hi);
    exp_rdy = (k >= ready_at) && !rd_pend;
    exp_rv  = rd_pend && (k >= rsp_from);
    cmd_valid = v; cmd_wr = wr; cmd_wdata = wd; rsp_ready = rr; rst = r;
    drv_en  = !exp_oe;
    // outside the capture cycle the far end may float the bus
    drv_val = (k == cap_cyc || $urandom_range(3) != 0) ? bus : 8'hxx;
    #1;
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, exp_rdy);
      chk("busy", busy, !exp_rdy);
      chk("buf_oe", buf_oe, exp_oe);
      chk("buf_in", buf_in, m_buf_in);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("no_contention", buf_oe && drv_en, 0);
`ifdef BIDIR_BUS_CTRL_TXN_CNT_EN
      chk("wr_count", wr_count, m_wr_cnt);
      chk("rd_count", rd_count, m_rd_cnt);
`endif
    end
    if (r) model_reset();
    else begin
      if (k == cap_cyc) m_rdata = bus;
      if (exp_rv && rr) begin
        rd_pend = 0; ready_at = k + 1;
        if (m_rd_cnt < 16'hFFFF) m_rd_cnt++;
      end
      if (k == wr_done && m_wr_cnt < 16'hFFFF) m_wr_cnt++;
      if (exp_rdy && v) begin
        if (wr) begin
          oe_lo = k + 1; oe_hi = k + D; m_buf_in = wd;
          ready_at = k + D + T + 1; wr_done = k + D + T;
        end else begin
          rd_pend = 1; cap_cyc = k + S; rsp_from = k + S + 1;
        end
      end
    end
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [7:0] bus);
    for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 1, 0, bus, 1);
  endtask

  initial begin
    cmd_valid = 0; cmd_wr = 0; cmd_wdata = 0; rsp_ready = 0; rst = 1;
    drv_en = 1; drv_val = 0;
    @(negedge clk);
    // reset held 2 cycles; first cycle has undefined pre-reset state
    tick(0, 0, 0, 0, 1, 8'h00, 0);
    tick(0, 0, 0, 0, 1, 8'h00, 1);
    idle(2, 8'h00);

    // single write of 10
    tick(1, 1, 8'd10, 0, 0, 8'h00, 1);
    idle(4, 8'h00);

    // read of 110 with consumer always ready
    tick(1, 0, 8'h00, 1, 0, 8'd110, 1);
    idle(5, 8'd110);

    // read of 120, consumer stalls 5 cycles while a write of 30 waits
    tick(1, 0, 8'h00, 0, 0, 8'd120, 1);
    for (int i = 0; i < S; i++) tick(1, 1, 8'd30, 0, 0, 8'd120, 1);
    for (int i = 0; i < 5; i++) tick(1, 1, 8'd30, 0, 0, 8'd121, 1);
    tick(1, 1, 8'd30, 1, 0, 8'd122, 1);
    tick(1, 1, 8'd30, 0, 0, 8'd122, 1);
    idle(4, 8'h00);

    // back-to-back writes 20 then 40, cmd_valid held high
    tick(1, 1, 8'd20, 0, 0, 8'h00, 1);
    for (int i = 0; i < D + T + 1; i++) tick(1, 1, 8'd40, 0, 0, 8'h00, 1);
    idle(4, 8'h00);

    // reset during the second DRIVE cycle of write 50
    tick(1, 1, 8'd50, 0, 0, 8'h00, 1);
    tick(0, 0, 8'h00, 0, 0, 8'h00, 1);
    tick(0, 0, 8'h00, 0, 1, 8'h00, 1);
    idle(2, 8'h00);

    // one write plus two reads after the reset
    tick(1, 1, 8'd60, 0, 0, 8'h00, 1);
    idle(4, 8'h00);
    tick(1, 0, 8'h00, 1, 0, 8'd70, 1);
    idle(4, 8'd70);
    tick(1, 0, 8'h00, 1, 0, 8'd80, 1);
    idle(5, 8'd80);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++)
      tick($urandom_range(1), $urandom_range(1), 8'($urandom), $urandom_range(2) == 0,
           $urandom_range(63) == 0, 8'($urandom), 1);
    idle(6, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
